bram_debug_sequencer: RTL and testbench
=======================================

Name: bram_debug_sequencer

Overview:
- Hardware replacement for the bench-driven load/run/dump flow around RV32Core.
- Accepts commands on a valid/ready port. Loads streamed words into the InstRAM or DataRAM debug port (port 2). Holds the core in reset, then releases it for a counted run. Streams memory contents back out on a valid/ready port.
- Sits between a host link (UART/JTAG bridge) and the CPU_Debug_* ports of RV32Core.

Parameters:
- LEN_W, 13, width of word-count/cycle-count field (max 4096 words = BRAMWORDS).
- RD_LAT, 1, BRAM port-2 read latency in cycles (1..3).
- RST_CYCLES, 4, cycles the core reset is held at the start of RUN (>=1).

Ports:
- CPU_CLK  in  1  single clock for sequencer, core and BRAMs.
- CPU_RST  in  1  synchronous, active-high reset of this block.
- Cmd_Valid  in  1  command valid.
- Cmd_Ready  out  1  high only in IDLE.
- Cmd_Op  in  3  000 LOAD_DATA, 001 LOAD_INST, 010 RUN, 011 DUMP_DATA, 100 DUMP_INST, others illegal.
- Cmd_Addr  in  32  base byte address; bits[1:0] forced to 0.
- Cmd_Len  in  LEN_W  word count (LOAD/DUMP) or run cycles (RUN).
- In_Valid / In_Ready / In_Data  in/out/in  1/1/32  load word stream.
- Out_Valid / Out_Ready / Out_Data / Out_Addr  out/in/out/out  1/1/32/32  dump stream.
- Core_Rst_Out  out  1  reset to RV32Core.
- CPU_Debug_DataRAM_A2 / WD2 / WE2  out  32/32/4  DataRAM port-2 drive.
- CPU_Debug_DataRAM_RD2  in  32  DataRAM port-2 read data.
- CPU_Debug_InstRAM_A2 / WD2 / WE2 / RD2  same for InstRAM.
- Busy  out  1  state != IDLE.
- Done  out  1  one-cycle pulse on command completion.
- Error  out  1  one-cycle pulse, coincident with Done, for illegal op.

Behaviour:
- Reset, synchronous on CPU_RST:
  - state=IDLE, Core_Rst_Out=1.
  - All A2/WD2=0, WE2=0.
  - Out_Valid=0, Out_Data=0, Out_Addr=0.
  - Done=0, Error=0, In_Ready=0.
- Reset mid-operation aborts at the next edge. Words already written stay written.
- All debug-port outputs are registered.
- The unselected RAM's WE2 is always 0 and its A2/WD2 hold their values.
- States: IDLE, LOAD, RUN_RST, RUN_EXEC, DUMP_ADDR, DUMP_WAIT, DUMP_OUT.
- IDLE:
  - Cmd_Ready=1. Handshake latches op, addr (low bits cleared), and remaining=Cmd_Len.
  - Cmd_Len==0 for any legal op: no memory or core activity; Done pulses the next cycle.
  - Illegal op: Done and Error pulse the next cycle; stays in IDLE.
- LOAD:
  - In_Ready=1 while remaining>0, giving 1 word/cycle throughput.
  - On an In_Valid&In_Ready edge: A2<=addr, WD2<=In_Data, WE2<=4'b1111 for exactly one cycle; addr+=4 (32-bit wrap); remaining-=1.
  - When the last word is accepted, In_Ready drops next cycle. WE2 returns to 0 one cycle later, with Done pulsed in that same cycle. Then IDLE.
- RUN:
  - RUN_RST holds Core_Rst_Out=1 for RST_CYCLES cycles.
  - RUN_EXEC holds Core_Rst_Out=0 for exactly Cmd_Len cycles.
  - Core_Rst_Out returns to 1 together with the Done pulse; then IDLE.
  - Core_Rst_Out=0 only in RUN_EXEC.
- DUMP:
  - DUMP_ADDR: A2<=addr.
  - DUMP_WAIT: RD2 is sampled at the (RD_LAT+1)-th rising edge after the edge that updated A2. Out_Data<=RD2, Out_Addr<=addr, Out_Valid<=1.
  - DUMP_OUT: Out_Valid and Out_Data are held stable until Out_Ready. On the Out_Valid&Out_Ready edge: Out_Valid<=0, addr+=4, remaining-=1.
  - If remaining reaches 0: Done, then IDLE. Otherwise return to DUMP_ADDR.
  - Throughput is RD_LAT+3 cycles/word when Out_Ready is held high.
- Cmd_Valid outside IDLE is ignored and not acknowledged.
- In_Valid outside LOAD is ignored.

Test Plan:
1. LOAD_DATA addr=0x0, len=4, words 11111111,22222222,33333333,44444444 streamed back-to-back -> four one-cycle WE2=1111 pulses at A2=0,4,8,C. InstRAM WE2 stays 0. Done 1 cycle after the last WE2.
2. DUMP_DATA addr=0x0, len=4 after test 1, Out_Ready=1 -> Out_Data sequence 11111111..44444444 with Out_Addr 0,4,8,C; then Done.
3. DUMP_INST len=2 with Out_Ready low 5 cycles per word -> Out_Valid/Out_Data stable throughout; exactly 2 transfers; no skipped or duplicated address.
4. RUN len=100 -> Core_Rst_Out=1 for 4 cycles, then 0 for exactly 100 cycles, then 1 with Done; Busy high throughout.
5. LOAD_INST len=8 with CPU_RST asserted after 3 accepted words -> IDLE, WE2=0 next edge, Core_Rst_Out=1. InstRAM words 0..2 written, word 3 onward untouched. A new command is accepted.
6. Cmd_Op=111 -> Done and Error pulse together, no WE2 activity. Cmd_Len=0 LOAD -> Done only, In_Ready never high.

Source files
------------

// File: rtl/bram_debug_sequencer.sv
// Command-driven load/run/dump sequencer for RV32Core's InstRAM/DataRAM debug ports.
// Replaces the bench-driven flow: streams words in, runs the core for N cycles, streams words out.
module bram_debug_sequencer #(
    parameter int unsigned LEN_W      = 13,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic             Cmd_Valid,
    output logic             Cmd_Ready,
    input  logic [2:0]       Cmd_Op,
    input  logic [31:0]      Cmd_Addr,
    input  logic [LEN_W-1:0] Cmd_Len,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [31:0]      In_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [31:0]      Out_Data,
    output logic [31:0]      Out_Addr,
    output logic             Core_Rst_Out,
    output logic [31:0]      CPU_Debug_DataRAM_A2,
    output logic [31:0]      CPU_Debug_DataRAM_WD2,
    output logic [3:0]       CPU_Debug_DataRAM_WE2,
    input  logic [31:0]      CPU_Debug_DataRAM_RD2,
    output logic [31:0]      CPU_Debug_InstRAM_A2,
    output logic [31:0]      CPU_Debug_InstRAM_WD2,
    output logic [3:0]       CPU_Debug_InstRAM_WE2,
    input  logic [31:0]      CPU_Debug_InstRAM_RD2,
    output logic             Busy,
    output logic             Done,
    output logic             Error
);

    typedef enum logic [2:0] {
        IDLE, LOAD, RUN_RST, RUN_EXEC, DUMP_ADDR, DUMP_WAIT, DUMP_OUT
    } state_e;

    typedef enum logic [2:0] {
        OP_LOAD_DATA = 3'b000,
        OP_LOAD_INST = 3'b001,
        OP_RUN       = 3'b010,
        OP_DUMP_DATA = 3'b011,
        OP_DUMP_INST = 3'b100
    } op_e;

    // One counter serves both the reset hold and the read-latency wait.
    localparam int unsigned CNT_MAX = (RST_CYCLES > RD_LAT + 1) ? RST_CYCLES : RD_LAT + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_inst_q, sel_inst_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [31:0]        out_addr_q, out_addr_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [31:0]        dram_a2_q, dram_a2_d, dram_wd2_q, dram_wd2_d;
    logic [3:0]         dram_we2_q, dram_we2_d;
    logic [31:0]        iram_a2_q, iram_a2_d, iram_wd2_q, iram_wd2_d;
    logic [3:0]         iram_we2_q, iram_we2_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        sel_inst_d  = sel_inst_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        core_rst_d  = core_rst_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        dram_a2_d   = dram_a2_q;
        dram_wd2_d  = dram_wd2_q;
        dram_we2_d  = '0;
        iram_a2_d   = iram_a2_q;
        iram_wd2_d  = iram_wd2_q;
        iram_we2_d  = '0;

        case (state_q)
            IDLE: begin
                if (Cmd_Valid) begin
                    addr_d = Cmd_Addr & ~32'h3;
                    rem_d  = Cmd_Len;
                    case (Cmd_Op)
                        OP_LOAD_DATA, OP_LOAD_INST: begin
                            sel_inst_d = (Cmd_Op == OP_LOAD_INST);
                            if (Cmd_Len == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d    = LOAD;
                                in_ready_d = 1'b1;
                            end
                        end
                        OP_RUN: begin
                            if (Cmd_Len == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = RUN_RST;
                                cnt_d   = CNT_W'(RST_CYCLES - 1);
                            end
                        end
                        OP_DUMP_DATA, OP_DUMP_INST: begin
                            sel_inst_d = (Cmd_Op == OP_DUMP_INST);
                            if (Cmd_Len == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = DUMP_ADDR;
                            end
                        end
                        default: begin
                            done_d  = 1'b1;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end

            // in_ready_q doubles as "words still outstanding"
            LOAD: begin
                if (in_ready_q) begin
                    if (In_Valid) begin
                        if (sel_inst_q) begin
                            iram_a2_d  = addr_q;
                            iram_wd2_d = In_Data;
                            iram_we2_d = '1;
                        end else begin
                            dram_a2_d  = addr_q;
                            dram_wd2_d = In_Data;
                            dram_we2_d = '1;
                        end
                        addr_d = addr_q + 32'd4;
                        rem_d  = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            in_ready_d = 1'b0;
                        end
                    end
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            RUN_RST: begin
                if (cnt_q == '0) begin
                    state_d    = RUN_EXEC;
                    core_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RUN_EXEC: begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    core_rst_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end

            DUMP_ADDR: begin
                if (sel_inst_q) begin
                    iram_a2_d = addr_q;
                end else begin
                    dram_a2_d = addr_q;
                end
                cnt_d   = CNT_W'(RD_LAT);
                state_d = DUMP_WAIT;
            end

            DUMP_WAIT: begin
                if (cnt_q == '0) begin
                    out_data_d  = sel_inst_q ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2;
                    out_addr_d  = addr_q;
                    out_valid_d = 1'b1;
                    state_d     = DUMP_OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DUMP_OUT: begin
                if (Out_Ready) begin
                    out_valid_d = 1'b0;
                    addr_d      = addr_q + 32'd4;
                    rem_d       = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DUMP_ADDR;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            sel_inst_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            dram_a2_q   <= '0;
            dram_wd2_q  <= '0;
            dram_we2_q  <= '0;
            iram_a2_q   <= '0;
            iram_wd2_q  <= '0;
            iram_we2_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            sel_inst_q  <= sel_inst_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            core_rst_q  <= core_rst_d;
            done_q      <= done_d;
            error_q     <= error_d;
            dram_a2_q   <= dram_a2_d;
            dram_wd2_q  <= dram_wd2_d;
            dram_we2_q  <= dram_we2_d;
            iram_a2_q   <= iram_a2_d;
            iram_wd2_q  <= iram_wd2_d;
            iram_we2_q  <= iram_we2_d;
        end
    end

    assign Cmd_Ready             = (state_q == IDLE);
    assign Busy                  = (state_q != IDLE);
    assign In_Ready              = in_ready_q;
    assign Out_Valid             = out_valid_q;
    assign Out_Data              = out_data_q;
    assign Out_Addr              = out_addr_q;
    assign Core_Rst_Out          = core_rst_q;
    assign Done                  = done_q;
    assign Error                 = error_q;
    assign CPU_Debug_DataRAM_A2  = dram_a2_q;
    assign CPU_Debug_DataRAM_WD2 = dram_wd2_q;
    assign CPU_Debug_DataRAM_WE2 = dram_we2_q;
    assign CPU_Debug_InstRAM_A2  = iram_a2_q;
    assign CPU_Debug_InstRAM_WD2 = iram_wd2_q;
    assign CPU_Debug_InstRAM_WE2 = iram_we2_q;

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Directed bench for bram_debug_sequencer with behavioural 1-cycle-latency BRAMs on port 2.
module tb_bram_debug_sequencer;

    localparam int unsigned LEN_W = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready;
    logic [2:0]       cmd_op;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             in_valid, in_ready;
    logic [31:0]      in_data;
    logic             out_valid, out_ready;
    logic [31:0]      out_data, out_addr;
    logic             core_rst;
    logic [31:0]      dram_a2, dram_wd2, dram_rd2;
    logic [3:0]       dram_we2;
    logic [31:0]      iram_a2, iram_wd2, iram_rd2;
    logic [3:0]       iram_we2;
    logic             busy, done, error;

    logic [31:0]      dmem [0:63];
    logic [31:0]      imem [0:63];
    logic             bd_we;
    logic [5:0]       bd_idx;
    logic [31:0]      bd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bram_debug_sequencer #(
        .LEN_W      (LEN_W),
        .RD_LAT     (1),
        .RST_CYCLES (4)
    ) dut (
        .CPU_CLK               (clk),
        .CPU_RST               (rst),
        .Cmd_Valid             (cmd_valid),
        .Cmd_Ready             (cmd_ready),
        .Cmd_Op                (cmd_op),
        .Cmd_Addr              (cmd_addr),
        .Cmd_Len               (cmd_len),
        .In_Valid              (in_valid),
        .In_Ready              (in_ready),
        .In_Data               (in_data),
        .Out_Valid             (out_valid),
        .Out_Ready             (out_ready),
        .Out_Data              (out_data),
        .Out_Addr              (out_addr),
        .Core_Rst_Out          (core_rst),
        .CPU_Debug_DataRAM_A2  (dram_a2),
        .CPU_Debug_DataRAM_WD2 (dram_wd2),
        .CPU_Debug_DataRAM_WE2 (dram_we2),
        .CPU_Debug_DataRAM_RD2 (dram_rd2),
        .CPU_Debug_InstRAM_A2  (iram_a2),
        .CPU_Debug_InstRAM_WD2 (iram_wd2),
        .CPU_Debug_InstRAM_WE2 (iram_we2),
        .CPU_Debug_InstRAM_RD2 (iram_rd2),
        .Busy                  (busy),
        .Done                  (done),
        .Error                 (error)
    );

    // Synchronous-read BRAM models, 1-cycle latency, byte write enables
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dram_we2[b]) dmem[dram_a2[7:2]][8*b +: 8] <= dram_wd2[8*b +: 8];
            if (iram_we2[b]) imem[iram_a2[7:2]][8*b +: 8] <= iram_wd2[8*b +: 8];
        end
        if (bd_we) imem[bd_idx] <= bd_data;
        dram_rd2 <= dmem[dram_a2[7:2]];
        iram_rd2 <= imem[iram_a2[7:2]];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] addr, input int len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic preset_imem(input int idx, input logic [31:0] data);
        bd_idx  = 6'(idx);
        bd_data = data;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_ready_busy got=%b%b exp=10", cmd_ready, busy); end
        total++; if ({in_ready, out_valid, done, error} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {in_ready, out_valid, done, error}); end
        total++; if ({dram_we2, iram_we2} !== 8'h0) begin bad++; $display("FAIL reset_we got=%h exp=00", {dram_we2, iram_we2}); end
        total++; if ({dram_a2, dram_wd2, iram_a2, iram_wd2, out_data, out_addr} !== '0) begin
            bad++; $display("FAIL reset_buses got=%h %h %h %h %h %h exp=0", dram_a2, dram_wd2, iram_a2, iram_wd2, out_data, out_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_data();
        logic [31:0] w;
        send_cmd(3'b000, 32'h0000_0003, 4);
        total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL load_start in_ready=%b busy=%b exp=11", in_ready, busy); end
        in_valid = 1'b1;
        in_data  = 32'h1111_1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            w = 32'h1111_1111 * 32'(i + 1);
            total++;
            if (dram_we2 !== 4'hF || dram_a2 !== 32'(i * 4) || dram_wd2 !== w) begin
                bad++; $display("FAIL load_word%0d we=%h a2=%h wd=%h exp we=f a2=%h wd=%h", i, dram_we2, dram_a2, dram_wd2, 32'(i * 4), w);
            end
            total++;
            if (iram_we2 !== 4'h0 || done !== 1'b0) begin
                bad++; $display("FAIL load_side%0d iram_we=%h done=%b exp 0 0", i, iram_we2, done);
            end
            if (i < 3) in_data = 32'h1111_1111 * 32'(i + 2);
            else in_valid = 1'b0;
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load_in_ready_drop got=%b exp=0", in_ready); end
        tick();
        total++; if (dram_we2 !== 4'h0 || done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL load_done we=%h done=%b busy=%b exp 0 1 0", dram_we2, done, busy);
        end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_dump_data();
        int n;
        logic [31:0] w;
        out_ready = 1'b1;
        send_cmd(3'b011, 32'h0, 4);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin tick(); n++; end while (out_valid !== 1'b1 && n < 20);
            w = 32'h1111_1111 * 32'(k + 1);
            total++;
            if (out_valid !== 1'b1 || out_data !== w || out_addr !== 32'(k * 4)) begin
                bad++; $display("FAIL dump_word%0d valid=%b data=%h addr=%h exp 1 %h %h", k, out_valid, out_data, out_addr, w, 32'(k * 4));
            end
            total++;
            if (n !== ((k == 0) ? 3 : 4)) begin
                bad++; $display("FAIL dump_gap%0d got=%0d exp=%0d", k, n, (k == 0) ? 3 : 4);
            end
        end
        tick();
        total++; if (done !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL dump_done done=%b valid=%b exp 1 0", done, out_valid); end
        tick();
    endtask

    task automatic test_dump_backpressure();
        int n;
        int stable_bad;
        int extra;
        logic [31:0] w;
        logic [31:0] a;
        preset_imem(16, 32'hCAFE_0010);
        preset_imem(17, 32'hCAFE_0011);
        out_ready = 1'b0;
        send_cmd(3'b100, 32'h40, 2);
        for (int k = 0; k < 2; k++) begin
            w = 32'hCAFE_0010 + 32'(k);
            a = 32'h40 + 32'(k * 4);
            n = 0;
            do begin tick(); n++; end while (out_valid !== 1'b1 && n < 20);
            total++;
            if (out_valid !== 1'b1 || out_data !== w || out_addr !== a) begin
                bad++; $display("FAIL bp_word%0d valid=%b data=%h addr=%h exp 1 %h %h", k, out_valid, out_data, out_addr, w, a);
            end
            stable_bad = 0;
            repeat (5) begin
                tick();
                if (out_valid !== 1'b1 || out_data !== w || out_addr !== a) stable_bad++;
            end
            total++; if (stable_bad !== 0) begin bad++; $display("FAIL bp_stable%0d unstable_cycles=%0d exp=0", k, stable_bad); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_xfer%0d valid=%b exp=0", k, out_valid); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bp_done got=%b exp=1", done); end
        extra = 0;
        repeat (8) begin
            tick();
            if (out_valid !== 1'b0) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL bp_extra_valid got=%0d exp=0", extra); end
        total++; if (iram_a2 !== 32'h44 || dram_a2 !== 32'hC) begin
            bad++; $display("FAIL bp_a2_hold iram_a2=%h dram_a2=%h exp 44 c", iram_a2, dram_a2);
        end
    endtask

    task automatic test_run();
        int hi;
        int lo;
        int errs;
        hi = 0; lo = 0; errs = 0;
        in_valid = 1'b1;
        in_data  = 32'hBAD0_BAD0;
        send_cmd(3'b010, 32'h0, 100);
        while (core_rst === 1'b1 && hi < 50) begin
            if (busy !== 1'b1 || cmd_ready !== 1'b0 || dram_we2 !== 4'h0 || iram_we2 !== 4'h0) errs++;
            hi++;
            tick();
        end
        while (core_rst === 1'b0 && lo < 500) begin
            if (busy !== 1'b1 || cmd_ready !== 1'b0 || dram_we2 !== 4'h0 || iram_we2 !== 4'h0) errs++;
            lo++;
            tick();
        end
        in_valid = 1'b0;
        total++; if (hi !== 4) begin bad++; $display("FAIL run_rst_cycles got=%0d exp=4", hi); end
        total++; if (lo !== 100) begin bad++; $display("FAIL run_exec_cycles got=%0d exp=100", lo); end
        total++; if (done !== 1'b1 || core_rst !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL run_end done=%b core_rst=%b busy=%b exp 1 1 0", done, core_rst, busy);
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL run_busy_we errors=%0d exp=0", errs); end
        tick();
    endtask

    task automatic test_load_reset();
        int errs;
        int n;
        logic [31:0] exp_w;
        for (int j = 0; j < 8; j++) preset_imem(j, 32'hDEAD_BEEF);
        send_cmd(3'b001, 32'h0, 8);
        in_valid = 1'b1;
        in_data  = 32'h1000_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            in_data = 32'h1000_0000 + 32'(i + 1);
        end
        rst = 1'b1;
        tick();
        total++; if (iram_we2 !== 4'h0 || core_rst !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL abort_state we=%h core_rst=%b busy=%b in_ready=%b exp 0 1 0 0", iram_we2, core_rst, busy, in_ready);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        errs = 0;
        for (int j = 0; j < 8; j++) begin
            exp_w = (j < 3) ? 32'h1000_0000 + 32'(j) : 32'hDEAD_BEEF;
            if (imem[j] !== exp_w) begin
                errs++;
                $display("FAIL abort_mem%0d got=%h exp=%h", j, imem[j], exp_w);
            end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL abort_mem_total errors=%0d exp=0", errs); end
        out_ready = 1'b1;
        send_cmd(3'b100, 32'h8, 1);
        n = 0;
        do begin tick(); n++; end while (out_valid !== 1'b1 && n < 20);
        total++; if (out_valid !== 1'b1 || out_data !== 32'h1000_0002 || out_addr !== 32'h8) begin
            bad++; $display("FAIL abort_new_cmd valid=%b data=%h addr=%h exp 1 10000002 8", out_valid, out_data, out_addr);
        end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_new_done got=%b exp=1", done); end
        tick();
    endtask

    task automatic test_illegal_and_zero();
        int errs;
        send_cmd(3'b111, 32'h0, 5);
        total++; if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0 || {dram_we2, iram_we2} !== 8'h0) begin
            bad++; $display("FAIL illegal_pulse done=%b error=%b busy=%b we=%h exp 1 1 0 00", done, error, busy, {dram_we2, iram_we2});
        end
        tick();
        total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL illegal_pulse_end done=%b error=%b exp 0 0", done, error); end
        send_cmd(3'b000, 32'h100, 0);
        total++; if (done !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL zero_load done=%b error=%b in_ready=%b exp 1 0 0", done, error, in_ready);
        end
        errs = 0;
        repeat (5) begin
            tick();
            if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || {dram_we2, iram_we2} !== 8'h0) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL zero_load_idle errors=%0d exp=0", errs); end
        send_cmd(3'b010, 32'h0, 0);
        total++; if (done !== 1'b1 || core_rst !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_run done=%b core_rst=%b busy=%b exp 1 1 0", done, core_rst, busy);
        end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b0;
        cmd_addr  = 32'h0;
        cmd_len   = '0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        bd_we     = 1'b0;
        bd_idx    = 6'h0;
        bd_data   = 32'h0;

        test_reset();
        test_load_data();
        test_dump_data();
        test_dump_backpressure();
        test_run();
        test_load_reset();
        test_illegal_and_zero();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
